// File: rtl/pspin_ingress_writer.sv
// Ring-buffer packet writer: takes matched AXIS packets, writes them beat-by-beat into fixed-size
// slots and emits one descriptor per packet. Optional counters under PSPIN_INGRESS_STATS_EN.
module pspin_ingress_writer #(
  parameter int unsigned AXIS_IF_DATA_WIDTH = 512,
  parameter int unsigned AXIS_IF_KEEP_WIDTH = AXIS_IF_DATA_WIDTH / 8,
  parameter int unsigned SLOT_BEATS         = 24,
  parameter int unsigned SLOT_COUNT         = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [AXIS_IF_DATA_WIDTH-1:0]             s_axis_tdata,
  input  logic [AXIS_IF_KEEP_WIDTH-1:0]             s_axis_tkeep,
  input  logic                                      s_axis_tvalid,
  output logic                                      s_axis_tready,
  input  logic                                      s_axis_tlast,
  output logic                                      mem_wr_en,
  output logic [$clog2(SLOT_COUNT*SLOT_BEATS)-1:0]  mem_wr_addr,
  output logic [AXIS_IF_DATA_WIDTH-1:0]             mem_wr_data,
  output logic [AXIS_IF_KEEP_WIDTH-1:0]             mem_wr_strb,
  output logic                                      desc_valid,
  input  logic                                      desc_ready,
  output logic [$clog2(SLOT_COUNT)-1:0]             desc_slot,
  output logic [15:0]                               desc_len,
  output logic                                      desc_trunc,
  input  logic                                      free_valid,
`ifdef PSPIN_INGRESS_STATS_EN
  output logic [31:0]                               stat_pkts,
  output logic [31:0]                               stat_trunc,
`endif
  output logic [$clog2(SLOT_COUNT):0]               occupancy
);

  localparam int unsigned AW = $clog2(SLOT_COUNT * SLOT_BEATS);
  localparam int unsigned SW = $clog2(SLOT_COUNT);
  localparam int unsigned OW = SW + 1;
  localparam int unsigned BW = $clog2(SLOT_BEATS + 1);
  localparam int unsigned PW = $clog2(AXIS_IF_KEEP_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StWrite, StDesc} state_e;

  state_e          state;
  logic [SW-1:0]   wr_ptr;
  logic [SW-1:0]   rd_ptr;
  logic [BW-1:0]   beat_cnt;
  logic            accept;
  logic            alloc;
  logic            free_eff;
  logic            in_slot;
  logic [PW-1:0]   beat_bytes;
  logic [16:0]     len_sum;
  logic [15:0]     len_sat;
  logic [AW-1:0]   beat_addr;

  function automatic logic [PW-1:0] popcnt(input logic [AXIS_IF_KEEP_WIDTH-1:0] k);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < AXIS_IF_KEEP_WIDTH; i++) c = c + PW'(k[i]);
    return c;
  endfunction

  always_comb begin
    s_axis_tready = 1'b0;
    if (!rst) begin
      case (state)
        StIdle:  s_axis_tready = (occupancy < OW'(SLOT_COUNT));
        StWrite: s_axis_tready = 1'b1;
        default: s_axis_tready = 1'b0;
      endcase
    end
  end

  assign accept     = s_axis_tvalid && s_axis_tready;
  assign alloc      = accept && (state == StIdle);
  assign free_eff   = free_valid && (occupancy != '0);
  // beat_cnt is 0 in IDLE, so beat 0 of every packet is always in range
  assign in_slot    = beat_cnt < BW'(SLOT_BEATS);
  assign beat_bytes = popcnt(s_axis_tkeep);
  assign len_sum    = (state == StIdle) ? 17'(beat_bytes) : ({1'b0, desc_len} + 17'(beat_bytes));
  assign len_sat    = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  assign beat_addr  = AW'(wr_ptr) * AW'(SLOT_BEATS) + AW'(beat_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      beat_cnt    <= '0;
      occupancy   <= '0;
      desc_valid  <= 1'b0;
      desc_slot   <= '0;
      desc_len    <= '0;
      desc_trunc  <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_wr_strb <= '0;
    end else begin
      mem_wr_en <= 1'b0;
      if (accept && in_slot) begin
        mem_wr_en   <= 1'b1;
        mem_wr_addr <= beat_addr;
        mem_wr_data <= s_axis_tdata;
        mem_wr_strb <= s_axis_tkeep;
      end

      case (state)
        StIdle: begin
          if (accept) begin
            desc_slot  <= wr_ptr;
            desc_len   <= len_sat;
            desc_trunc <= 1'b0;
            beat_cnt   <= BW'(1);
            if (s_axis_tlast) begin
              state      <= StDesc;
              desc_valid <= 1'b1;
            end else begin
              state <= StWrite;
            end
          end
        end
        StWrite: begin
          if (accept) begin
            if (in_slot) begin
              desc_len <= len_sat;
              beat_cnt <= beat_cnt + BW'(1);
            end else begin
              desc_trunc <= 1'b1;
            end
            if (s_axis_tlast) begin
              state      <= StDesc;
              desc_valid <= 1'b1;
            end
          end
        end
        StDesc: begin
          if (desc_ready) begin
            desc_valid <= 1'b0;
            wr_ptr     <= wr_ptr + SW'(1);
            beat_cnt   <= '0;
            state      <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase

      if (alloc && !free_eff)      occupancy <= occupancy + OW'(1);
      else if (!alloc && free_eff) occupancy <= occupancy - OW'(1);

      if (free_eff) rd_ptr <= rd_ptr + SW'(1);
    end
  end

`ifdef PSPIN_INGRESS_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pkts  <= '0;
      stat_trunc <= '0;
    end else if (desc_valid && desc_ready) begin
      stat_pkts <= stat_pkts + 32'd1;
      if (desc_trunc) stat_trunc <= stat_trunc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pspin_ingress_writer.sv
// Directed bench for pspin_ingress_writer: table of single-packet vectors plus hand-written
// sequences for ring-full, descriptor back-pressure, mid-packet reset and spurious free.
module tb_pspin_ingress_writer;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int SB = 24;
  localparam int SC = 8;
  localparam int AW = 8;
  localparam int SW = 3;
  localparam logic [KW-1:0] FULL = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [KW-1:0] mem_wr_strb;
  logic          desc_valid;
  logic          desc_ready = 1'b0;
  logic [SW-1:0] desc_slot;
  logic [15:0]   desc_len;
  logic          desc_trunc;
  logic          free_valid = 1'b0;
  logic [SW:0]   occupancy;
`ifdef PSPIN_INGRESS_STATS_EN
  logic [31:0]   stat_pkts;
  logic [31:0]   stat_trunc;
`endif

  int errors = 0;
  int checks = 0;

  pspin_ingress_writer dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_strb   (mem_wr_strb),
    .desc_valid    (desc_valid),
    .desc_ready    (desc_ready),
    .desc_slot     (desc_slot),
    .desc_len      (desc_len),
    .desc_trunc    (desc_trunc),
    .free_valid    (free_valid),
`ifdef PSPIN_INGRESS_STATS_EN
    .stat_pkts     (stat_pkts),
    .stat_trunc    (stat_trunc),
`endif
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] beat_data(input int b);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(b);
    return {16{w}};
  endfunction

  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    desc_ready    = 1'b0;
    free_valid    = 1'b0;
    rst           = 1'b1;
    tick();
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_desc_valid", 64'(desc_valid), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_wr_en", 64'(mem_wr_en), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_tready", 64'(s_axis_tready), 64'd1);
  endtask

  // Presents a packet; checks the registered write that follows each accepted beat.
  task automatic send_pkt(input int nbeats, input logic [KW-1:0] last_keep, input int slot);
    for (int b = 0; b < nbeats; b++) begin
      int t;
      s_axis_tdata  = beat_data(b);
      s_axis_tkeep  = (b == nbeats - 1) ? last_keep : FULL;
      s_axis_tlast  = (b == nbeats - 1);
      s_axis_tvalid = 1'b1;
      t = 0;
      while (!s_axis_tready && t < 50) begin
        tick();
        t++;
      end
      if (t == 50) begin
        check("tready_timeout", 64'd0, 64'd1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        return;
      end
      tick();
      check("wr_en", 64'(mem_wr_en), 64'(b < SB));
      if (b < SB) begin
        check("wr_addr", 64'(mem_wr_addr), 64'(slot * SB + b));
        check("wr_strb", mem_wr_strb, (b == nbeats - 1) ? last_keep : FULL);
        check("wr_data", 64'(mem_wr_data == beat_data(b)), 64'd1);
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic desc_hs(input int slot, input int len, input bit trunc);
    check("desc_valid", 64'(desc_valid), 64'd1);
    check("desc_slot", 64'(desc_slot), 64'(slot));
    check("desc_len", 64'(desc_len), 64'(len));
    check("desc_trunc", 64'(desc_trunc), 64'(trunc));
    check("desc_tready", 64'(s_axis_tready), 64'd0);
    desc_ready = 1'b1;
    tick();
    desc_ready = 1'b0;
    check("desc_done", 64'(desc_valid), 64'd0);
  endtask

  typedef struct {
    int          beats;
    logic [63:0] last_keep;
    int          exp_len;
    bit          exp_trunc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{beats: 3,  last_keep: 64'hFFFF, exp_len: 144,  exp_trunc: 1'b0};
    vecs[1] = '{beats: 1,  last_keep: 64'h0,    exp_len: 0,    exp_trunc: 1'b0};
    vecs[2] = '{beats: 30, last_keep: FULL,     exp_len: 1536, exp_trunc: 1'b1};
    vecs[3] = '{beats: 2,  last_keep: 64'hFF,   exp_len: 72,   exp_trunc: 1'b0};
    vecs[4] = '{beats: 24, last_keep: FULL,     exp_len: 1536, exp_trunc: 1'b0};
    vecs[5] = '{beats: 25, last_keep: 64'h1,    exp_len: 1536, exp_trunc: 1'b1};

    tick();
    for (int i = 0; i < 6; i++) begin
      do_reset();
      send_pkt(vecs[i].beats, vecs[i].last_keep, 0);
      check("vec_occupancy", 64'(occupancy), 64'd1);
      desc_hs(0, vecs[i].exp_len, vecs[i].exp_trunc);
`ifdef PSPIN_INGRESS_STATS_EN
      check("stat_pkts", 64'(stat_pkts), 64'd1);
      check("stat_trunc", 64'(stat_trunc), 64'(vecs[i].exp_trunc));
`endif
      free_valid = 1'b1;
      tick();
      free_valid = 1'b0;
      check("vec_free_occ", 64'(occupancy), 64'd0);
    end

    // Fill the ring, then release one slot and reuse slot 0.
    do_reset();
    for (int i = 0; i < SC; i++) begin
      send_pkt(1, FULL, i);
      desc_hs(i, 64, 1'b0);
    end
    check("full_occupancy", 64'(occupancy), 64'd8);
    check("full_tready", 64'(s_axis_tready), 64'd0);
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_no_write", 64'(mem_wr_en), 64'd0);
      check("full_hold_occ", 64'(occupancy), 64'd8);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    free_valid = 1'b1;
    tick();
    free_valid = 1'b0;
    check("freed_occupancy", 64'(occupancy), 64'd7);
    check("freed_tready", 64'(s_axis_tready), 64'd1);
    send_pkt(1, FULL, 0);
    check("ninth_occupancy", 64'(occupancy), 64'd8);
    desc_hs(0, 64, 1'b0);

    // Descriptor back-pressure, then free concurrent with allocation.
    do_reset();
    send_pkt(2, 64'hF, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("desc_hold", 64'(desc_valid && desc_slot == 0 && desc_len == 16'd68 &&
                             !desc_trunc && !s_axis_tready), 64'd1);
    end
    desc_hs(0, 68, 1'b0);
    check("bp_occupancy", 64'(occupancy), 64'd1);
    s_axis_tdata  = beat_data(0);
    s_axis_tkeep  = FULL;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    free_valid    = 1'b1;
    check("concur_tready", 64'(s_axis_tready), 64'd1);
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    free_valid    = 1'b0;
    check("concur_occupancy", 64'(occupancy), 64'd1);
    check("concur_wr_en", 64'(mem_wr_en), 64'd1);
    check("concur_wr_addr", 64'(mem_wr_addr), 64'd24);
    check("concur_rd_ptr", 64'(dut.rd_ptr), 64'd1);
    desc_hs(1, 64, 1'b0);

    // Reset during beat 2 of a 5-beat packet.
    do_reset();
    s_axis_tkeep  = FULL;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_tready", 64'(s_axis_tready), 64'd0);
    check("midrst_wr_en", 64'(mem_wr_en), 64'd0);
    check("midrst_desc", 64'({desc_valid, desc_trunc, desc_slot, desc_len}), 64'd0);
    check("midrst_occupancy", 64'(occupancy), 64'd0);
    s_axis_tvalid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_release_tready", 64'(s_axis_tready), 64'd1);
    send_pkt(1, FULL, 0);
    check("midrst_occ_after", 64'(occupancy), 64'd1);
    desc_hs(0, 64, 1'b0);

    // Spurious free at empty ring.
    do_reset();
    free_valid = 1'b1;
    tick();
    free_valid = 1'b0;
    check("empty_free_occ", 64'(occupancy), 64'd0);
    check("empty_free_rd_ptr", 64'(dut.rd_ptr), 64'd0);
    send_pkt(1, 64'h3, 0);
    desc_hs(0, 2, 1'b0);
    free_valid = 1'b1;
    tick();
    free_valid = 1'b0;
    check("real_free_rd_ptr", 64'(dut.rd_ptr), 64'd1);
    check("real_free_occ", 64'(occupancy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
